// File: rtl/writeback_register_file.sv
// Writeback stage: selects the result, commits it to the 32-entry GPR file and HI/LO, serves two decode read ports.
// Latency: reads are combinational, with same-cycle write-through; state updates on the rising clk edge.
// Backpressure: none; a write is accepted on every enabled cycle, and a write in a reset cycle is dropped.
//
// Ports:
//   clk, reset_n                   - clock and synchronous active-low reset (clears GPRs, HI, LO)
//   *_writeback inputs             - GPR/HI-LO write enables, destination, ALU/load/HI/LO data
//   read_address_1/2 -> read_data_1/2 - decode read ports, bypassing the in-flight GPR write
//   HI_output, LO_output           - HI/LO, bypassing the in-flight HI/LO write
//   result_writeback               - selected writeback value, used for forwarding
//   register_v0                    - stored GPR[2], not bypassed
module writeback_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  register_write_writeback,
    input  logic                  memory_to_register_writeback,
    input  logic                  hi_lo_write_writeback,
    input  logic [ADDR_WIDTH-1:0] write_register_writeback,
    input  logic [DATA_WIDTH-1:0] ALU_output_writeback,
    input  logic [DATA_WIDTH-1:0] read_data_writeback,
    input  logic [DATA_WIDTH-1:0] ALU_HI_output_writeback,
    input  logic [DATA_WIDTH-1:0] ALU_LO_output_writeback,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    input  logic [ADDR_WIDTH-1:0] read_address_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [DATA_WIDTH-1:0] HI_output,
    output logic [DATA_WIDTH-1:0] LO_output,
    output logic [DATA_WIDTH-1:0] result_writeback,
    output logic [DATA_WIDTH-1:0] register_v0
);

    logic [DATA_WIDTH-1:0] gpr [REG_COUNT];
    logic [DATA_WIDTH-1:0] hi_reg;
    logic [DATA_WIDTH-1:0] lo_reg;
    logic                  gpr_write;
    logic                  hi_lo_write;

    assign result_writeback = memory_to_register_writeback ? read_data_writeback
                                                           : ALU_output_writeback;

    // Qualified enables: reset wins over writes, and $zero is never a real destination.
    // The same qualifiers gate the bypass, so readers never see a write that will not land.
    assign gpr_write   = reset_n && register_write_writeback && (write_register_writeback != '0);
    assign hi_lo_write = reset_n && hi_lo_write_writeback;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                gpr[i] <= '0;
            end
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (gpr_write) begin
                gpr[write_register_writeback] <= result_writeback;
            end
            if (hi_lo_write) begin
                hi_reg <= ALU_HI_output_writeback;
                lo_reg <= ALU_LO_output_writeback;
            end
        end
    end

    always_comb begin
        read_data_1 = gpr[read_address_1];
        if (read_address_1 == '0) begin
            read_data_1 = '0;
        end else if (gpr_write && (read_address_1 == write_register_writeback)) begin
            read_data_1 = result_writeback;
        end
    end

    always_comb begin
        read_data_2 = gpr[read_address_2];
        if (read_address_2 == '0) begin
            read_data_2 = '0;
        end else if (gpr_write && (read_address_2 == write_register_writeback)) begin
            read_data_2 = result_writeback;
        end
    end

    assign HI_output = hi_lo_write ? ALU_HI_output_writeback : hi_reg;
    assign LO_output = hi_lo_write ? ALU_LO_output_writeback : lo_reg;

    // Architectural $v0 at the cycle boundary: intentionally not bypassed.
    assign register_v0 = gpr[2];

endmodule

// File: tb/tb_writeback_register_file.sv
module tb_writeback_register_file;

    logic        clk;
    logic        reset_n;
    logic        register_write_writeback;
    logic        memory_to_register_writeback;
    logic        hi_lo_write_writeback;
    logic [4:0]  write_register_writeback;
    logic [31:0] ALU_output_writeback;
    logic [31:0] read_data_writeback;
    logic [31:0] ALU_HI_output_writeback;
    logic [31:0] ALU_LO_output_writeback;
    logic [4:0]  read_address_1;
    logic [4:0]  read_address_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] HI_output;
    logic [31:0] LO_output;
    logic [31:0] result_writeback;
    logic [31:0] register_v0;

    writeback_register_file #(
        .DATA_WIDTH(32),
        .REG_COUNT (32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .register_write_writeback    (register_write_writeback),
        .memory_to_register_writeback(memory_to_register_writeback),
        .hi_lo_write_writeback       (hi_lo_write_writeback),
        .write_register_writeback    (write_register_writeback),
        .ALU_output_writeback        (ALU_output_writeback),
        .read_data_writeback         (read_data_writeback),
        .ALU_HI_output_writeback     (ALU_HI_output_writeback),
        .ALU_LO_output_writeback     (ALU_LO_output_writeback),
        .read_address_1              (read_address_1),
        .read_address_2              (read_address_2),
        .read_data_1                 (read_data_1),
        .read_data_2                 (read_data_2),
        .HI_output                   (HI_output),
        .LO_output                   (LO_output),
        .result_writeback            (result_writeback),
        .register_v0                 (register_v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state as the specification describes it.
    logic [31:0] model_gpr [32];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_result();
        return memory_to_register_writeback ? read_data_writeback : ALU_output_writeback;
    endfunction

    // A read sees the in-flight write only if that write will actually land at the edge.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (reset_n && register_write_writeback && write_register_writeback == a) return model_result();
        return model_gpr[a];
    endfunction

    task automatic drive(input logic rst, rw, m2r, hlw, input logic [4:0] wa,
                         input logic [31:0] alu, rdv, hi, lo, input logic [4:0] a1, a2);
        reset_n                      = rst;
        register_write_writeback     = rw;
        memory_to_register_writeback = m2r;
        hi_lo_write_writeback        = hlw;
        write_register_writeback     = wa;
        ALU_output_writeback         = alu;
        read_data_writeback          = rdv;
        ALU_HI_output_writeback      = hi;
        ALU_LO_output_writeback      = lo;
        read_address_1               = a1;
        read_address_2               = a2;
    endtask

    task automatic idle(input logic [4:0] a1, a2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, $urandom, $urandom, $urandom, $urandom, a1, a2);
    endtask

    // Compare every output against the model, away from the active edge.
    task automatic step_check();
        @(negedge clk);
        check("result_writeback", result_writeback, model_result());
        check("read_data_1", read_data_1, model_read(read_address_1));
        check("read_data_2", read_data_2, model_read(read_address_2));
        check("HI_output", HI_output, (reset_n && hi_lo_write_writeback) ? ALU_HI_output_writeback : model_hi);
        check("LO_output", LO_output, (reset_n && hi_lo_write_writeback) ? ALU_LO_output_writeback : model_lo);
        check("register_v0", register_v0, model_gpr[2]);
    endtask

    // Advance the model across the edge with the inputs that were stable before it.
    task automatic step_commit();
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model_gpr[i] = 32'h0;
            model_hi = 32'h0;
            model_lo = 32'h0;
        end else begin
            if (register_write_writeback && write_register_writeback != 5'd0)
                model_gpr[write_register_writeback] = model_result();
            if (hi_lo_write_writeback) begin
                model_hi = ALU_HI_output_writeback;
                model_lo = ALU_LO_output_writeback;
            end
        end
        #1;
    endtask

    task automatic cycle();
        step_check();
        step_commit();
    endtask

    initial begin
        logic [4:0] wa;
        for (int i = 0; i < 32; i++) model_gpr[i] = 32'h0;
        model_hi = 32'h0;
        model_lo = 32'h0;

        // Initial reset edge: storage is undefined before it, so no comparison yet.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        step_commit();

        // Reset then read every register on both ports.
        for (int a = 0; a < 32; a++) begin
            idle(a[4:0], 5'(31 - a));
            step_check();
            check("rst_rd1", read_data_1, 32'h0);
            check("rst_rd2", read_data_2, 32'h0);
            step_commit();
        end
        check("rst_hi", HI_output, 32'h0);
        check("rst_lo", LO_output, 32'h0);
        check("rst_v0", register_v0, 32'h0);

        // Write with ALU select, then with load select.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h12345678, 32'hCAFEF00D, 32'h0, 32'h0, 5'd1, 5'd4);
        step_check();
        check("sel_alu", result_writeback, 32'h12345678);
        step_commit();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 32'h00000001, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd0);
        step_check();
        check("sel_mem", result_writeback, 32'hDEADBEEF);
        check("r5_after", read_data_1, 32'h12345678);
        step_commit();
        idle(5'd6, 5'd5);
        step_check();
        check("r6_after", read_data_1, 32'hDEADBEEF);
        check("r5_port2", read_data_2, 32'h12345678);
        step_commit();

        // $zero protection, same cycle and after the edge.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        step_check();
        check("zero_same", read_data_1, 32'h0);
        step_commit();
        idle(5'd0, 5'd0);
        step_check();
        check("zero_after", read_data_1, 32'h0);
        step_commit();

        // Bypass on both ports.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'hAAAA0000, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0000BBBB, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);
        step_check();
        check("byp_rd1", read_data_1, 32'h0000BBBB);
        check("byp_rd2", read_data_2, 32'h0000BBBB);
        check("byp_v0", register_v0, 32'h0);
        step_commit();

        // HI/LO with a concurrent write of $v0.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h00000042, 32'h0, 32'h00000001, 32'hFFFFFFFE, 5'd2, 5'd7);
        step_check();
        check("hl_byp_hi", HI_output, 32'h00000001);
        check("hl_byp_lo", LO_output, 32'hFFFFFFFE);
        check("v0_nobyp", register_v0, 32'h0);
        check("v0_rd_byp", read_data_1, 32'h00000042);
        step_commit();
        idle(5'd7, 5'd2);
        step_check();
        check("hl_hi", HI_output, 32'h00000001);
        check("hl_lo", LO_output, 32'hFFFFFFFE);
        check("hl_v0", register_v0, 32'h00000042);
        check("r7_kept", read_data_1, 32'h0000BBBB);
        step_commit();

        // Reset with writes pending: bypass suppressed, writes lost.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h00000099, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h00000055, 32'h0, 32'h12121212, 32'h34343434, 5'd3, 5'd2);
        step_check();
        check("rstw_rd_stored", read_data_1, 32'h00000099);
        check("rstw_hi_stored", HI_output, 32'h00000001);
        step_commit();
        idle(5'd3, 5'd7);
        step_check();
        check("rstw_r3", read_data_1, 32'h0);
        check("rstw_r7", read_data_2, 32'h0);
        check("rstw_hi", HI_output, 32'h0);
        check("rstw_lo", LO_output, 32'h0);
        check("rstw_v0", register_v0, 32'h0);
        step_commit();

        // Random traffic against the model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            wa = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) wa = 5'd2;
            drive($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  wa, $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_register_file.md
Name: writeback_register_file

Overview:
Consumer end of the memory/writeback pipeline register. Selects the writeback result, commits it to the 32-entry general-purpose register file, and commits the HI/LO pair. Serves the decode stage's two combinational read ports, with write-through bypass so same-cycle writeback is visible. Also exposes $v0 for the top-level CPU output.

Parameters:
DATA_WIDTH, 32, width of every register and data port
REG_COUNT, 32, number of architectural GPRs; register 0 hardwired to zero
ADDR_WIDTH, 5, register index width, log2(REG_COUNT)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous reset, active-low
register_write_writeback  input  1  GPR write enable from the pipeline register
memory_to_register_writeback  input  1  1: result = read_data; 0: result = ALU output
hi_lo_write_writeback  input  1  HI/LO write enable (MULT/DIV/MTHI/MTLO already merged upstream)
write_register_writeback  input  ADDR_WIDTH  destination GPR index
ALU_output_writeback  input  DATA_WIDTH  ALU result
read_data_writeback  input  DATA_WIDTH  load data
ALU_HI_output_writeback  input  DATA_WIDTH  new HI value
ALU_LO_output_writeback  input  DATA_WIDTH  new LO value
read_address_1  input  ADDR_WIDTH  decode read port 1 index
read_address_2  input  ADDR_WIDTH  decode read port 2 index
read_data_1  output  DATA_WIDTH  GPR[read_address_1]
read_data_2  output  DATA_WIDTH  GPR[read_address_2]
HI_output  output  DATA_WIDTH  current HI
LO_output  output  DATA_WIDTH  current LO
result_writeback  output  DATA_WIDTH  selected writeback value, fed to the forwarding unit
register_v0  output  DATA_WIDTH  GPR[2]

Behaviour:
- One clock domain. Reset is synchronous, active-low: on a rising clk edge with reset_n=0, all GPRs, HI and LO become 0. Reset has priority over any write in the same cycle.
- result_writeback is combinational: memory_to_register_writeback ? read_data_writeback : ALU_output_writeback.
- GPR write: on a rising edge with reset_n=1, register_write_writeback=1 and write_register_writeback!=0, GPR[write_register_writeback] <= result_writeback. Writes to index 0 are discarded, so GPR[0] reads 0 at all times.
- HI/LO write: on a rising edge with reset_n=1 and hi_lo_write_writeback=1, HI <= ALU_HI_output_writeback and LO <= ALU_LO_output_writeback. Both update together; there is no partial write.
- GPR write and HI/LO write are independent and may occur in the same cycle.
- Read ports are combinational with zero latency.
- Read ports use write-through bypass. If register_write_writeback=1, write_register_writeback!=0, reset_n=1 and read_address_n equals write_register_writeback, then read_data_n = result_writeback. Otherwise read_data_n = stored GPR value. Index 0 always reads 0.
- The bypass is suppressed while reset_n=0. During that cycle, reads return stored values; the registers clear at the edge.
- HI_output and LO_output use the same bypass: while hi_lo_write_writeback=1 and reset_n=1, they show the incoming values.
- register_v0 returns the stored GPR[2] with no bypass. It is the architectural value at the cycle boundary.
- Both read ports may address the same register, including the one being written; both get the bypassed value.
- Reset mid-operation: a pending write in the reset cycle is lost. The next cycle sees all zeros.
- Outputs after reset: read_data_1/2 = 0, HI_output = 0, LO_output = 0, register_v0 = 0. result_writeback follows its inputs.
- No X propagation: uninitialised storage is impossible after the first reset edge.

Test Plan:
1. Reset then read: hold reset_n=0 for 1 edge, then sweep read_address_1/2 over 0..31 -> every read returns 0x00000000; HI_output=LO_output=register_v0=0.
2. Write and select:
   - write $5 with memory_to_register=0 and ALU_output=0x12345678 -> next cycle read_data_1(addr 5)=0x12345678.
   - write $6 with memory_to_register=1, read_data=0xDEADBEEF and ALU_output=0x1 -> $6=0xDEADBEEF.
3. $zero protection: register_write=1, write_register=0, ALU_output=0xFFFFFFFF -> read_data_1(addr 0)=0 in the same cycle and after the edge.
4. Bypass: $7 holds 0xAAAA0000. Write $7 with 0x0000BBBB while both ports read 7 -> both return 0x0000BBBB in the same cycle; register_v0 is unchanged unless the address is 2.
5. HI/LO: hi_lo_write=1, HI=0x00000001, LO=0xFFFFFFFE, concurrently GPR write $2=0x42 -> HI_output/LO_output bypass immediately; after the edge, HI=1, LO=0xFFFFFFFE, register_v0=0x42.
6. Reset with write pending: reset_n=0 with register_write=1 to $3=0x55 and hi_lo_write=1 -> after the edge, $3=0, HI=0, LO=0.
